// File: rtl/lc3b_hazard_stall_ctrl.sv
// lc3b_hazard_stall_ctrl
// Hazard and stall controller for the 5-stage LC-3b pipeline. It decides each
// cycle which pipeline registers load, when ID/EX captures the all-zero NOP
// control word, and when IF/ID is squashed.
// It handles three cases:
//   - memory-wait freezes
//   - load-use bubbles
//   - taken-branch flushes (the branch resolves in MEM)
// Optional feature macro: HAZARD_STATS_EN adds 32-bit event counters
// (stall cycles, load-use bubbles, accepted branches).
module lc3b_hazard_stall_ctrl #(
    parameter int REG_W        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_src1_i,
    input  logic [REG_W-1:0] id_src2_i,
    input  logic             id_use_src1_i,
    input  logic             id_use_src2_i,
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic             imem_resp_i,
    input  logic             dmem_req_i,
    input  logic             dmem_resp_i,
    input  logic             branch_taken_i,
    output logic             load_pc_o,
    output logic             load_if_id_o,
    output logic             load_id_ex_o,
    output logic             load_ex_mem_o,
    output logic             load_mem_wb_o,
    output logic             nop_sel_ex_o,
    output logic             flush_if_id_o,
    output logic             mem_timeout_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stat_stall_cycles_o,
    output logic [31:0]      stat_bubbles_o,
    output logic [31:0]      stat_flushes_o
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_STALL = 2'd1,
        BUBBLE    = 2'd2,
        FLUSH     = 2'd3
    } state_e;

    localparam logic        MULTI_FLUSH  = (FLUSH_CYCLES > 1);
    localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL  = 16'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        freeze;
    logic        load_use;
    logic        do_branch;
    logic        do_bubble;
    logic        stall_evt;
    logic        bubble_evt;
    logic        branch_evt;

    assign freeze   = !imem_resp_i | (dmem_req_i & !dmem_resp_i);
    assign load_use = ex_mem_read_i &
                      ((id_use_src1_i & (id_src1_i == ex_dest_i)) |
                       (id_use_src2_i & (id_src2_i == ex_dest_i)));

    // Next-state and output decode: freeze beats branch beats load-use.
    // The outputs are forced to the safe reset pattern while reset is low.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        load_pc_o     = 1'b1;
        load_if_id_o  = 1'b1;
        load_id_ex_o  = 1'b1;
        load_ex_mem_o = 1'b1;
        load_mem_wb_o = 1'b1;
        nop_sel_ex_o  = 1'b0;
        flush_if_id_o = 1'b0;
        do_branch     = 1'b0;
        do_bubble     = 1'b0;
        stall_evt     = 1'b0;
        bubble_evt    = 1'b0;
        branch_evt    = 1'b0;

        if (freeze) begin
            load_pc_o     = 1'b0;
            load_if_id_o  = 1'b0;
            load_id_ex_o  = 1'b0;
            load_ex_mem_o = 1'b0;
            load_mem_wb_o = 1'b0;
            stall_evt     = 1'b1;
            if (wait_cnt_q != TIMEOUT_VAL) begin
                wait_cnt_d = wait_cnt_q + 16'd1;
            end
            if (wait_cnt_d == TIMEOUT_VAL) begin
                mem_timeout_d = 1'b1;
            end
            if (state_q == RUN) begin
                state_d = MEM_STALL;
            end
        end else begin
            wait_cnt_d = '0;
            case (state_q)
                RUN, MEM_STALL: begin
                    state_d = RUN;
                    if (branch_taken_i) begin
                        do_branch = 1'b1;
                    end else if (load_use) begin
                        do_bubble = 1'b1;
                    end
                end
                BUBBLE: begin
                    state_d = RUN;
                    if (branch_taken_i) begin
                        do_branch = 1'b1;
                    end
                end
                FLUSH: begin
                    nop_sel_ex_o  = 1'b1;
                    flush_if_id_o = 1'b1;
                    if (branch_taken_i) begin
                        do_branch = 1'b1;
                    end else if (flush_cnt_q <= 2'd1) begin
                        state_d     = RUN;
                        flush_cnt_d = '0;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            if (do_branch) begin
                nop_sel_ex_o  = 1'b1;
                flush_if_id_o = 1'b1;
                branch_evt    = 1'b1;
                if (MULTI_FLUSH) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_RELOAD;
                end else begin
                    state_d     = RUN;
                    flush_cnt_d = '0;
                end
            end else if (do_bubble) begin
                load_pc_o    = 1'b0;
                load_if_id_o = 1'b0;
                nop_sel_ex_o = 1'b1;
                bubble_evt   = 1'b1;
                state_d      = BUBBLE;
            end
        end

        if (!rst_n) begin
            load_pc_o     = 1'b0;
            load_if_id_o  = 1'b0;
            load_id_ex_o  = 1'b0;
            load_ex_mem_o = 1'b0;
            load_mem_wb_o = 1'b0;
            nop_sel_ex_o  = 1'b1;
            flush_if_id_o = 1'b0;
        end
    end

    assign mem_timeout_o = mem_timeout_q;

    // State, flush countdown, memory-wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            flush_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stat_stall_q, stat_bubble_q, stat_flush_q;

    // Free-running event counters that wrap modulo 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_stall_q  <= '0;
            stat_bubble_q <= '0;
            stat_flush_q  <= '0;
        end else begin
            if (stall_evt) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
            if (bubble_evt) begin
                stat_bubble_q <= stat_bubble_q + 32'd1;
            end
            if (branch_evt) begin
                stat_flush_q <= stat_flush_q + 32'd1;
            end
        end
    end

    assign stat_stall_cycles_o = stat_stall_q;
    assign stat_bubbles_o      = stat_bubble_q;
    assign stat_flushes_o      = stat_flush_q;
`else
    logic unused_evt;
    assign unused_evt = stall_evt ^ bubble_evt ^ branch_evt;
`endif

endmodule
